// File: rtl/div_sequencer.sv
// div_sequencer: front-end controller for the iterative divider core.
// Captures operands on a ctrl_DIV pulse, steps the core through counts 0..33,
// captures quotient/overflow at LAST_STEP, and presents a registered result with a
// single-cycle data_resultRDY pulse. Divide-by-zero forces result 0 and exception 1.
// Optional build macro: DIV_ZERO_FASTPATH_EN -- a zero divisor skips the core run
// and reports the exception one edge after capture instead of after the full sequence.
module div_sequencer #(
  parameter int DATA_W    = 32,
  parameter int COUNT_W   = 6,
  parameter int LAST_STEP = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_DIV,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic [DATA_W-1:0] core_result,
  input  logic              core_overflow,
  output logic [DATA_W-1:0] core_dividend,
  output logic [DATA_W-1:0] core_divisor,
  output logic [COUNT_W-1:0] core_count,
  output logic              busy,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY
);

  // ZERO is only reachable when the fast path is compiled in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } seqState;

  localparam logic [COUNT_W-1:0] lastCount  = COUNT_W'(LAST_STEP);
  localparam logic [COUNT_W-1:0] resetCount = COUNT_W'(LAST_STEP + 1);
  localparam logic [COUNT_W-1:0] countOne   = COUNT_W'(1);

  seqState             state, stateNext;
  logic [DATA_W-1:0]   dividendQ, dividendNext;
  logic [DATA_W-1:0]   divisorQ, divisorNext;
  logic [COUNT_W-1:0]  countQ, countNext;
  logic                dzQ, dzNext;
  logic [DATA_W-1:0]   resultQ, resultNext;
  logic                excQ, excNext;
  logic                rdyQ, rdyNext;
  logic                divisorIsZero;

  assign divisorIsZero = (data_operandB == '0);

  // Next-state and datapath update; a new ctrl_DIV always wins over the current state.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; a missing default here would infer a latch.
    stateNext    = state;
    dividendNext = dividendQ;
    divisorNext  = divisorQ;
    countNext    = countQ;
    dzNext       = dzQ;
    resultNext   = resultQ;
    excNext      = excQ;
    rdyNext      = 1'b0;

    if (ctrl_DIV) begin
      dividendNext = data_operandA;
      divisorNext  = data_operandB;
      dzNext       = divisorIsZero;
      countNext    = '0;
`ifdef DIV_ZERO_FASTPATH_EN
      stateNext    = divisorIsZero ? ZERO : RUN;
`else
      stateNext    = RUN;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          countNext = '0;
        end
        RUN: begin
          if (countQ == lastCount) begin
            // Core output is valid this cycle; a zero divisor overrides whatever it shows.
            resultNext = dzQ ? '0 : core_result;
            excNext    = core_overflow | dzQ;
            rdyNext    = 1'b1;
            countNext  = resetCount;
          end else if (countQ == resetCount) begin
            countNext = '0;
            stateNext = IDLE;
          end else begin
            countNext = countQ + countOne;
          end
        end
        ZERO: begin
          countNext = '0;
`ifdef DIV_ZERO_FASTPATH_EN
          // First edge in ZERO reports the exception, the second returns to IDLE.
          if (!rdyQ) begin
            resultNext = '0;
            excNext    = 1'b1;
            rdyNext    = 1'b1;
          end else begin
            stateNext = IDLE;
          end
`else
          stateNext = IDLE;
`endif
        end
        default: begin
          countNext = '0;
          stateNext = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Datapath registers: held operands, step count, and the registered result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dividendQ <= '0;
      divisorQ  <= '0;
      countQ    <= '0;
      dzQ       <= 1'b0;
      resultQ   <= '0;
      excQ      <= 1'b0;
      rdyQ      <= 1'b0;
    end else begin
      dividendQ <= dividendNext;
      divisorQ  <= divisorNext;
      countQ    <= countNext;
      dzQ       <= dzNext;
      resultQ   <= resultNext;
      excQ      <= excNext;
      rdyQ      <= rdyNext;
    end
  end

  assign core_dividend  = dividendQ;
  assign core_divisor   = divisorQ;
  assign core_count     = countQ;
  assign busy           = (state == RUN) || (state == ZERO);
  assign data_result    = resultQ;
  assign data_exception = excQ;
  assign data_resultRDY = rdyQ;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized and directed stimulus against a transaction-level
// reference model (op start edge, elapsed edges, expected quotient). A small behavioural
// divider core answers correctly only at LAST_STEP and returns junk otherwise, so a
// capture at the wrong step shows up as a wrong result.
module tb_div_sequencer;
  localparam int DATA_W    = 32;
  localparam int COUNT_W   = 6;
  localparam int LAST_STEP = 32;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              ctrl_DIV = 1'b0;
  logic [DATA_W-1:0] data_operandA = '0;
  logic [DATA_W-1:0] data_operandB = '0;
  logic [DATA_W-1:0] core_result;
  logic              core_overflow;
  logic [DATA_W-1:0] core_dividend;
  logic [DATA_W-1:0] core_divisor;
  logic [COUNT_W-1:0] core_count;
  logic              busy;
  logic [DATA_W-1:0] data_result;
  logic              data_exception;
  logic              data_resultRDY;

  div_sequencer #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .LAST_STEP(LAST_STEP)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .core_result(core_result), .core_overflow(core_overflow),
    .core_dividend(core_dividend), .core_divisor(core_divisor), .core_count(core_count),
    .busy(busy), .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  // Signed quotient as the real divider computes it; the one overflowing case wraps.
  function automatic logic [31:0] refQuot(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return 32'd0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    return 32'(sa / sb);
  endfunction

  function automatic logic refOvf(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Behavioural core: correct answer only at LAST_STEP, junk everywhere else.
  logic [31:0] junkRes = 32'h1234_5678;
  logic        junkOvf = 1'b1;
  always @(negedge clock) begin
    junkRes = $urandom;
    junkOvf = 1'($urandom_range(0, 1));
  end
  assign core_result   = (core_count == COUNT_W'(LAST_STEP) && core_divisor != 0)
                         ? refQuot(core_dividend, core_divisor) : junkRes;
  assign core_overflow = (core_count == COUNT_W'(LAST_STEP))
                         ? refOvf(core_dividend, core_divisor) : junkOvf;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state: one op in flight, counted in edges since its start.
  bit          active   = 1'b0;
  bit          zeroPath = 1'b0;
  int          elapsed  = 0;
  logic [31:0] opA = '0, opB = '0;
  logic [31:0] expRes = '0, lastRes = '0;
  logic        expExc = 1'b0, lastExc = 1'b0;

  // Advance one clock edge, update the model from what was driven, check every output.
  task automatic step();
    logic        sCtrl;
    logic [31:0] sA, sB;
    bit          rdyExp;
    int          countExp;
    sCtrl = ctrl_DIV;
    sA    = data_operandA;
    sB    = data_operandB;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      active = 1'b0; opA = '0; opB = '0; lastRes = '0; lastExc = 1'b0;
    end else if (sCtrl) begin
      active   = 1'b1;
      elapsed  = 0;
      zeroPath = FAST && (sB == 0);
      opA      = sA;
      opB      = sB;
      expRes   = (sB == 0) ? 32'd0 : refQuot(sA, sB);
      expExc   = (sB == 0) || refOvf(sA, sB);
    end else if (active) begin
      elapsed++;
      if (zeroPath ? (elapsed >= 2) : (elapsed >= LAST_STEP + 2)) active = 1'b0;
    end
    rdyExp   = active && (zeroPath ? (elapsed == 1) : (elapsed == LAST_STEP + 1));
    countExp = (active && !zeroPath) ? elapsed : 0;
    if (rdyExp) begin
      lastRes = expRes;
      lastExc = expExc;
    end
    check("rdy", 32'(data_resultRDY), 32'(rdyExp));
    check("count", 32'(core_count), 32'(countExp));
    check("busy", 32'(busy), 32'(active));
    check("result", data_result, lastRes);
    check("exception", 32'(data_exception), 32'(lastExc));
    check("dividend", core_dividend, opA);
    check("divisor", core_divisor, opB);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    step();
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Step until RDY (bounded) and check the latency in edges after the start edge.
  task automatic waitRdy(input string tag, input int expLat);
    int n;
    n = 0;
    while (data_resultRDY !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(expLat));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] a, b;
    int gap, abortAt;

    // Reset values.
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // 100 / 7
    issue(32'd100, 32'd7);
    waitRdy("t1", 33);
    check("t1_result", data_result, 32'd14);
    check("t1_exc", 32'(data_exception), 32'd0);
    runCycles(3);

    // -100 / 7; pulse width and busy release come from the per-cycle model checks.
    issue(-32'sd100, 32'd7);
    waitRdy("t2", 33);
    check("t2_result", data_result, 32'hFFFF_FFF2);
    runCycles(2);
    check("t2_busy_low", 32'(busy), 32'd0);

    // 5 / 0
    issue(32'd5, 32'd0);
    waitRdy("t3", FAST ? 1 : 33);
    check("t3_result", data_result, 32'd0);
    check("t3_exc", 32'(data_exception), 32'd1);
    runCycles(3);

    // Abort 100/7 at count 10 with 9/3.
    issue(32'd100, 32'd7);
    runCycles(10);
    issue(32'd9, 32'd3);
    waitRdy("t4", 33);
    check("t4_result", data_result, 32'd3);
    runCycles(40);

    // Asynchronous reset at count 20.
    issue(32'd100, 32'd7);
    runCycles(20);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_count", 32'(core_count), 32'd0);
    check("t5_async_result", data_result, 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_dividend", core_dividend, 32'd0);
    step();
    reset_n = 1'b1;
    runCycles(40);

    // New op issued during the RDY cycle of 100/7.
    issue(32'd100, 32'd7);
    waitRdy("t6a", 33);
    check("t6a_result", data_result, 32'd14);
    issue(32'd8, 32'd2);
    waitRdy("t6b", 33);
    check("t6b_result", data_result, 32'd4);
    runCycles(2);

    // Most-negative / -1: exception comes from the core overflow.
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    waitRdy("ovf", 33);
    check("ovf_exc", 32'(data_exception), 32'd1);
    runCycles(2);

    // Random ops with random idle gaps, zero divisors and mid-run aborts.
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = -32'($urandom_range(1, 9));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(a, b);
      if ($urandom_range(0, 3) == 0) begin
        abortAt = $urandom_range(0, 33);
        runCycles(abortAt);
        issue($urandom, 32'($urandom_range(1, 1000)));
      end
      gap = $urandom_range(30, 40);
      runCycles(gap);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
